// File: rtl/number_detector.sv
// ASCII stream sniffer: finds 9-digit numbers written either as a contiguous run
// or as three space-separated groups of three, then replays the digits on data_out.
module number_detector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       write,
    output logic       long,
    output logic       short
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_G1   = 3'd1,
        ST_SEP1 = 3'd2,
        ST_G2   = 3'd3,
        ST_SEP2 = 3'd4,
        ST_G3   = 3'd5,
        ST_RUN  = 3'd6
    } state_t;

    function automatic logic is_digit_f(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    logic [7:0] byte_r;
    logic       valid_r;
    logic       is_digit_s;
    logic       is_space_s;
    logic       start_s;

    state_t     state_r;
    state_t     state_nx_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nx_s;
    logic       prev_digit_r;
    logic [3:0] ndig_r;
    logic [3:0] cap_idx_s;
    logic       cap_en_s;
    logic [7:0] cap_r [0:8];
    logic       hit_long_s;
    logic       hit_short_s;
    logic       hit_long_r;
    logic       hit_short_r;

    logic [7:0] out_buf_r [0:8];
    logic [3:0] idx_r;
    logic       busy_r;

    assign is_digit_s = is_digit_f(byte_r);
    assign is_space_s = (byte_r == 8'h20);
    assign start_s    = is_digit_s && !prev_digit_r;

    // Classifier stage: capture accepted byte and its valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_r  <= 8'h00;
            valid_r <= 1'b0;
        end else begin
            valid_r <= enable;
            if (enable) begin
                byte_r <= data_in;
            end
        end
    end

    // Detector state register, capture buffer and hit flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            prev_digit_r <= 1'b0;
            ndig_r       <= 4'd0;
            hit_long_r   <= 1'b0;
            hit_short_r  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                cap_r[i] <= 8'h00;
            end
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            hit_long_r  <= hit_long_s;
            hit_short_r <= hit_short_s;
            if (valid_r) begin
                prev_digit_r <= is_digit_s;
            end
            if (cap_en_s) begin
                cap_r[cap_idx_s] <= byte_r;
                ndig_r           <= cap_idx_s + 4'd1;
            end
        end
    end

    // Next-state logic; a failing byte can never open a new candidate, so deviations land in IDLE
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        if (valid_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_nx_s = ST_G1;
                        cnt_nx_s   = 4'd1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_G1: begin
                    if (is_digit_s) begin
                        state_nx_s = (cnt_r == 4'd3) ? ST_RUN : ST_G1;
                        cnt_nx_s   = cnt_r + 4'd1;
                    end else if (is_space_s && (cnt_r == 4'd3)) begin
                        state_nx_s = ST_SEP1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_SEP1, ST_SEP2: begin
                    if (is_digit_s) begin
                        state_nx_s = (state_r == ST_SEP1) ? ST_G2 : ST_G3;
                        cnt_nx_s   = 4'd1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_G2: begin
                    if (is_digit_s && (cnt_r < 4'd3)) begin
                        cnt_nx_s = cnt_r + 4'd1;
                    end else if (is_space_s && (cnt_r == 4'd3)) begin
                        state_nx_s = ST_SEP2;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_G3: begin
                    if (is_digit_s && (cnt_r < 4'd3)) begin
                        cnt_nx_s = cnt_r + 4'd1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (is_digit_s && (cnt_r < 4'd9)) begin
                        cnt_nx_s = cnt_r + 4'd1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Detector outputs: match pulses and digit capture strobe
    always_comb begin
        hit_long_s  = 1'b0;
        hit_short_s = 1'b0;
        cap_en_s    = 1'b0;
        cap_idx_s   = (state_r == ST_IDLE) ? 4'd0 : ndig_r;
        if (valid_r) begin
            hit_long_s  = (state_r == ST_G3) && (cnt_r == 4'd3) && !is_digit_s;
            hit_short_s = (state_r == ST_RUN) && (cnt_r == 4'd9) && !is_digit_s;
            cap_en_s    = is_digit_s && (state_nx_s != ST_IDLE);
        end else begin
            cap_en_s = 1'b0;
        end
    end

    // Serializer: replay the 9 captured digits, one per cycle; a new hand-off overrides residue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 8'h00;
            write    <= 1'b0;
            long     <= 1'b0;
            short    <= 1'b0;
            idx_r    <= 4'd0;
            busy_r   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                out_buf_r[i] <= 8'h00;
            end
        end else begin
            long  <= hit_long_r;
            short <= hit_short_r;
            if (busy_r) begin
                write    <= 1'b1;
                data_out <= out_buf_r[idx_r];
                idx_r    <= idx_r + 4'd1;
                busy_r   <= (idx_r != 4'd8);
            end else begin
                write <= 1'b0;
            end
            if (hit_long_r || hit_short_r) begin
                out_buf_r <= cap_r;
                idx_r     <= 4'd0;
                busy_r    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_number_detector.sv
// Bench for number_detector: directed scenarios plus randomized streams checked
// against a token-prefix reference model with per-cycle expected outputs.
module tb_number_detector;

    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       write;
    logic       long_o;
    logic       short_o;

    number_detector dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .data_in  (data_in),
        .data_out (data_out),
        .write    (write),
        .long     (long_o),
        .short    (short_o)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         wr_seen = 0;
    int         long_seen = 0;
    int         short_seen = 0;

    bit         exp_long  [0:MAXC-1];
    bit         exp_short [0:MAXC-1];
    bit         exp_write [0:MAXC-1];
    logic [7:0] exp_data  [0:MAXC-1];

    logic [7:0] tok[$];
    bit         active = 1'b0;
    bit         prev_dig = 1'b0;

    function automatic bit is_d(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic bit short_ok();
        if (tok.size() > 9) return 1'b0;
        foreach (tok[i]) if (!is_d(tok[i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit long_ok();
        if (tok.size() > 11) return 1'b0;
        foreach (tok[i]) begin
            if (i == 3 || i == 7) begin
                if (tok[i] != 8'h20) return 1'b0;
            end else begin
                if (!is_d(tok[i])) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic schedule(input bit is_long, input int k);
        int n;
        n = 0;
        if (is_long) exp_long[k+2] = 1'b1;
        else exp_short[k+2] = 1'b1;
        foreach (tok[i]) begin
            if (is_d(tok[i])) begin
                exp_write[k+3+n] = 1'b1;
                exp_data[k+3+n]  = tok[i];
                n++;
            end
        end
    endtask

    // Reference: a candidate is the token since its start; it lives while it is a prefix of a pattern
    task automatic model_accept(input logic [7:0] b, input int k);
        bit consumed;
        bit d;
        consumed = 1'b0;
        d = is_d(b);
        if (active) begin
            if (!d && tok.size() == 9 && short_ok()) begin
                schedule(1'b0, k);
                active = 1'b0;
                consumed = 1'b1;
            end else if (!d && tok.size() == 11 && long_ok()) begin
                schedule(1'b1, k);
                active = 1'b0;
                consumed = 1'b1;
            end else begin
                tok.push_back(b);
                if (short_ok() || long_ok()) consumed = 1'b1;
                else active = 1'b0;
            end
        end
        if (!consumed && d && !prev_dig) begin
            active = 1'b1;
            tok.delete();
            tok.push_back(b);
        end
        prev_dig = d;
    endtask

    task automatic model_reset();
        active = 1'b0;
        prev_dig = 1'b0;
        tok.delete();
        for (int i = cyc + 1; i < MAXC; i++) begin
            exp_long[i] = 1'b0;
            exp_short[i] = 1'b0;
            exp_write[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        checks += 3;
        assert (long_o === exp_long[cyc]) else begin
            errors++;
            $error("FAIL long cyc=%0d observed=%b expected=%b", cyc, long_o, exp_long[cyc]);
        end
        assert (short_o === exp_short[cyc]) else begin
            errors++;
            $error("FAIL short cyc=%0d observed=%b expected=%b", cyc, short_o, exp_short[cyc]);
        end
        assert (write === exp_write[cyc]) else begin
            errors++;
            $error("FAIL write cyc=%0d observed=%b expected=%b", cyc, write, exp_write[cyc]);
        end
        if (exp_write[cyc]) begin
            checks++;
            assert (data_out === exp_data[cyc]) else begin
                errors++;
                $error("FAIL data_out cyc=%0d observed=%h expected=%h", cyc, data_out, exp_data[cyc]);
            end
        end
        if (write === 1'b1) wr_seen++;
        if (long_o === 1'b1) long_seen++;
        if (short_o === 1'b1) short_seen++;
    endtask

    task automatic tick(input logic en, input logic [7:0] b);
        enable = en;
        data_in = b;
        if (en && rst_n) model_accept(b, cyc + 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            while (gaps && $urandom_range(0, 7) == 0) tick(1'b0, 8'($urandom_range(0, 255)));
            tick(1'b1, s[i]);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    function automatic string rand_digits(input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = {s, string'(8'(8'h30 + $urandom_range(0, 9)))};
        return s;
    endfunction

    initial begin
        string s;
        int base_w, base_l, base_s, guard;
        string noise;
        noise = "ab x1 \n5";

        // Reset state
        rst_n = 1'b0;
        enable = 1'b0;
        data_in = 8'h00;
        #2;
        checks += 4;
        assert (write === 1'b0) else begin errors++; $error("FAIL rst_write observed=%b expected=0", write); end
        assert (long_o === 1'b0) else begin errors++; $error("FAIL rst_long observed=%b expected=0", long_o); end
        assert (short_o === 1'b0) else begin errors++; $error("FAIL rst_short observed=%b expected=0", short_o); end
        assert (data_out === 8'h00) else begin errors++; $error("FAIL rst_data observed=%h expected=00", data_out); end
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        rst_n = 1'b1;
        drain(2);

        // Combined long + short stream
        base_w = wr_seen; base_l = long_seen; base_s = short_seen;
        send_str("a729 892 561ff729892561gsdf", 1'b0);
        drain(14);
        checks += 3;
        assert (wr_seen - base_w == 18) else begin errors++; $error("FAIL t1_writes observed=%0d expected=18", wr_seen - base_w); end
        assert (long_seen - base_l == 1) else begin errors++; $error("FAIL t1_long observed=%0d expected=1", long_seen - base_l); end
        assert (short_seen - base_s == 1) else begin errors++; $error("FAIL t1_short observed=%0d expected=1", short_seen - base_s); end

        // Near-miss patterns produce nothing
        base_w = wr_seen;
        send_str("x1234567890x", 1'b0);
        send_str("x12345678x", 1'b0);
        send_str("x729  892 561x", 1'b0);
        send_str("x72 9892 561x", 1'b0);
        send_str("5729 892 561x", 1'b0);
        drain(14);
        checks++;
        assert (wr_seen == base_w) else begin errors++; $error("FAIL neg_writes observed=%0d expected=%0d", wr_seen, base_w); end

        // Enable gap with garbage inside a number
        send_str("x1234", 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'($urandom_range(0, 255)));
        base_s = short_seen;
        send_str("56789x", 1'b0);
        drain(14);
        checks++;
        assert (short_seen - base_s == 1) else begin errors++; $error("FAIL gap_short observed=%0d expected=1", short_seen - base_s); end

        // Long followed by a run that starts after a space
        send_str("x111 222 333 444555666x", 1'b0);
        drain(14);

        // Reset in the middle of output
        send_str("x123456789x", 1'b0);
        base_w = wr_seen;
        guard = 0;
        while (wr_seen - base_w < 4 && guard < 40) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        checks++;
        assert (wr_seen - base_w == 4) else begin errors++; $error("FAIL rst_mid_wait observed=%0d expected=4", wr_seen - base_w); end
        rst_n = 1'b0;
        #1;
        checks++;
        assert (write === 1'b0) else begin errors++; $error("FAIL rst_mid_write observed=%b expected=0", write); end
        model_reset();
        tick(1'b0, 8'h00);
        rst_n = 1'b1;
        drain(12);
        send_str("x987654321x", 1'b0);
        drain(14);

        // Randomized segments with random enable gaps
        for (int seg = 0; seg < 150; seg++) begin
            case ($urandom_range(0, 4))
                0: s = rand_digits(9);
                1: s = {rand_digits(3), " ", rand_digits(3), " ", rand_digits(3)};
                2: s = rand_digits($urandom_range(8, 10));
                3: s = {rand_digits(3), " ", rand_digits($urandom_range(2, 4)), " ", rand_digits(3)};
                default: begin
                    s = "";
                    for (int j = 0; j < $urandom_range(1, 5); j++)
                        s = {s, string'(noise[$urandom_range(0, noise.len() - 1)])};
                end
            endcase
            s = {string'(noise[$urandom_range(0, 4)]), s};
            send_str(s, 1'b1);
        end
        send_str("x", 1'b0);
        drain(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
